rr_arbiter16: RTL and testbench

- Round-robin arbiter that shares a single resource among 16 requesters.
- Each requester presents a level request and holds the resource until it releases the request or a hold-time limit expires.
- Winner selection is rotating-priority encoding over 16 request bits: the first active request at or above a pointer wins, searching upward with wrap.
- Sits in front of any shared datapath; gnt_idx drives the datapath's select/mux lines.

---
 rtl/rr_arbiter16.sv | 128 ++++++++++++
 tb/tb_rr_arbiter16.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 level requesters with optional hold-time limit.
// gnt/gnt_idx/gnt_valid/timeout are all registered; the owner keeps the grant
// until it drops its request or MAX_HOLD consecutive cycles have elapsed.
module rr_arbiter16 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CW       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        en,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout
);

  localparam int unsigned N  = 16;
  localparam int unsigned IW = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    gnt_d;
  logic [IW-1:0]   idx_d;
  logic            valid_d;
  logic            timeout_d;

  logic [IW-1:0]   arb_ptr_c;
  logic [IW-1:0]   win_c;
  logic            any_req_c;
  logic            owner_req_c;
  logic            at_limit_c;

  // First set bit of r at or above p, searching upward with wrap.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    logic [IW-1:0] i;
    logic          found;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      i = p + IW'(k);
      if (!found && r[i]) begin
        w     = i;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Winner search: from IDLE use ptr, on a hand-over the old owner goes last.
  always_comb begin
    arb_ptr_c   = (state_q == GRANT) ? (gnt_idx + IW'(1)) : ptr_q;
    win_c       = pick(req, arb_ptr_c);
    any_req_c   = |req;
    owner_req_c = req[gnt_idx];
    at_limit_c  = (MAX_HOLD != 0) && (cnt_q >= CW'(MAX_HOLD));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt;
    idx_d     = gnt_idx;
    valid_d   = gnt_valid;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en && any_req_c) begin
          state_d = GRANT;
          gnt_d   = N'(1) << win_c;
          idx_d   = win_c;
          valid_d = 1'b1;
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        if (owner_req_c && !at_limit_c) begin
          cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
        end else begin
          timeout_d = owner_req_c;
          ptr_d     = gnt_idx + IW'(1);
          if (en && any_req_c) begin
            gnt_d   = N'(1) << win_c;
            idx_d   = win_c;
            valid_d = 1'b1;
            cnt_d   = CW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16 (MAX_HOLD=4): directed scenarios with
// literal expectations plus a randomized phase against a behavioural model.
module tb_rr_arbiter16;

  localparam int MH = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        en;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  rr_arbiter16 #(.MAX_HOLD(MH), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .en        (en),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: owner index (-1 = idle), rotation pointer, cycles held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 0;

  function automatic int pick(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_owner < 0) begin
        if (en && req != 16'h0) begin
          m_owner = pick(req, m_ptr);
          m_held  = 1;
        end
      end else if (req[m_owner] && (MH == 0 || m_held < MH)) begin
        m_held++;
      end else begin
        m_to  = req[m_owner];
        m_ptr = (m_owner + 1) % 16;
        if (en && req != 16'h0) begin
          m_owner = pick(req, m_ptr);
          m_held  = 1;
        end else begin
          m_owner = -1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_gnt",       gnt,              (m_owner < 0) ? 16'h0 : (16'h1 << m_owner));
      chk("m_gnt_idx",   16'(gnt_idx),     (m_owner < 0) ? 16'h0 : 16'(m_owner));
      chk("m_gnt_valid", 16'(gnt_valid),   16'(m_owner >= 0));
      chk("m_timeout",   16'(timeout),     16'(m_to));
      chk("onehot0",     16'($onehot0(gnt)), 16'h1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 16'h0;
    en    = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'h0;
    en    = 1'b1;
    do_reset();
    cmp_en = 1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_gnt", gnt, 16'h0);
      chk("idle_valid", 16'(gnt_valid), 16'h0);
      chk("idle_idx", 16'(gnt_idx), 16'h0);
      chk("idle_to", 16'(timeout), 16'h0);
    end

    // Back-to-back hand-over 0 -> 15 without an idle bubble.
    req = 16'h8001;
    tick();
    chk("first_gnt", gnt, 16'h0001);
    req = 16'h8000;
    tick();
    chk("handover_gnt", gnt, 16'h8000);
    chk("handover_idx", 16'(gnt_idx), 16'd15);
    req = 16'h0;
    tick();
    chk("release_idle", gnt, 16'h0);

    // Fairness: each owner holds 2 cycles then drops for one.
    do_reset();
    req = 16'hFFFF;
    tick();
    for (int e = 0; e <= 16; e++) begin
      chk("fair_idx", 16'(gnt_idx), 16'(e % 16));
      tick();
      req = 16'hFFFF & ~(16'h1 << (e % 16));
      tick();
      req = 16'hFFFF;
    end

    // Hold limit between two requesters.
    do_reset();
    req = 16'h0006;
    for (int t = 1; t <= 9; t++) begin
      tick();
      chk("to2_gnt", gnt, (t <= 4 || t == 9) ? 16'h0002 : 16'h0004);
      chk("to2_pulse", 16'(timeout), 16'(t == 5 || t == 9));
    end

    // Hold limit with a single requester: re-granted with no gap.
    do_reset();
    req = 16'h0020;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk("to1_gnt", gnt, 16'h0020);
      chk("to1_pulse", 16'(timeout), 16'(t == 5 || t == 9));
    end

    // Enable low keeps the owner but blocks new grants; then reset mid-grant.
    do_reset();
    req = 16'h0008;
    tick();
    chk("en_first", gnt, 16'h0008);
    en  = 1'b0;
    req = 16'h0018;
    tick();
    tick();
    chk("en_hold", gnt, 16'h0008);
    req = 16'h0010;
    tick();
    chk("en_block", gnt, 16'h0000);
    tick();
    chk("en_block2", 16'(gnt_valid), 16'h0);
    en = 1'b1;
    tick();
    chk("en_regrant", gnt, 16'h0010);
    chk("en_regrant_idx", 16'(gnt_idx), 16'd4);
    rst_n = 1'b0;
    tick();
    chk("rst_gnt", gnt, 16'h0);
    chk("rst_valid", 16'(gnt_valid), 16'h0);
    chk("rst_to", 16'(timeout), 16'h0);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       req = 16'($urandom);
        1:       req = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2:       req = 16'h1 << $urandom_range(0, 15);
        default: req = req;
      endcase
      en    = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
